// File: rtl/gauss_pass_sequencer.sv
// Frame sequencer for the multi-scale Gaussian pyramid: feeds FRAME_PIXELS pixels per
// pass into the blur path, waits for them to drain, and steps the kernel index per pass.
module gauss_pass_sequencer #(
  parameter int FRAME_PIXELS  = 4096,
  parameter int NUM_SCALES    = 5,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       src_valid,
  output logic       src_rd_en,
  input  logic       gauss_full,
  output logic       gauss_wr_en,
  input  logic       gauss_out_valid,
  output logic [2:0] scale_sel,
  output logic       busy,
  output logic       pass_done,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, NEXT, FIN} state_t;

  state_t          state, state_nxt;
  logic [15:0]     in_cnt, out_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            accept, last_in, out_full, out_inc, timeout, last_scale, aborting;

  assign aborting   = abort && (state != IDLE);
  assign accept     = (state == FEED) && src_valid && !gauss_full && !abort &&
                      (in_cnt < 16'(FRAME_PIXELS));
  assign last_in    = (in_cnt == 16'(FRAME_PIXELS - 1));
  assign out_full   = (out_cnt == 16'(FRAME_PIXELS));
  assign out_inc    = ((state == FEED) || (state == DRAIN)) && gauss_out_valid && !out_full;
  // Fires on the edge where the idle count would reach DRAIN_TIMEOUT.
  assign timeout    = !gauss_out_valid && (idle_cnt == IW'(DRAIN_TIMEOUT - 1));
  assign last_scale = (scale_sel == 3'(NUM_SCALES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (aborting) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = FEED;
        FEED:    if (accept && last_in) state_nxt = DRAIN;
        DRAIN:   if (out_full) state_nxt = NEXT;
                 else if (timeout) state_nxt = IDLE;
        NEXT:    state_nxt = last_scale ? FIN : FEED;
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Enables are pure combinational on the FEED handshake; reset forces state to IDLE,
  // which drops them without waiting for a clock.
  always_comb begin
    src_rd_en   = accept;
    gauss_wr_en = accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scale_sel <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      idle_cnt  <= '0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      pass_done <= (state_nxt == NEXT);
      done      <= (state_nxt == FIN);
      if (state == IDLE) begin
        idle_cnt <= '0;
        if (start) begin
          scale_sel <= '0;
          in_cnt    <= '0;
          out_cnt   <= '0;
          err       <= 1'b0;
        end
      end else if (aborting) begin
        in_cnt   <= '0;
        out_cnt  <= '0;
        idle_cnt <= '0;
      end else if ((state == DRAIN) && !out_full && timeout) begin
        err      <= 1'b1;
        in_cnt   <= '0;
        out_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        if (accept)  in_cnt  <= in_cnt + 16'd1;
        if (out_inc) out_cnt <= out_cnt + 16'd1;
        if (state == DRAIN) idle_cnt <= gauss_out_valid ? '0 : idle_cnt + 1'b1;
        else                idle_cnt <= '0;
        if ((state == NEXT) && !last_scale) begin
          scale_sel <= scale_sel + 3'd1;
          in_cnt    <= '0;
          out_cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gauss_pass_sequencer.sv
// Directed bench for gauss_pass_sequencer with FRAME_PIXELS=4, NUM_SCALES=2, DRAIN_TIMEOUT=8.
module tb_gauss_pass_sequencer;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic       src_valid = 1'b0, gauss_full = 1'b0, gauss_out_valid = 1'b0;
  logic       src_rd_en, gauss_wr_en, busy, pass_done, done, err;
  logic [2:0] scale_sel;

  int tests = 0, fails = 0;
  int wr_cnt = 0, pd_cnt = 0, done_cnt = 0;
  logic [7:0] pd_hist = '0;
  int wb, pb, db, n;

  always #5 clk = ~clk;

  gauss_pass_sequencer #(.FRAME_PIXELS(4), .NUM_SCALES(2), .DRAIN_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_valid(src_valid), .src_rd_en(src_rd_en),
    .gauss_full(gauss_full), .gauss_wr_en(gauss_wr_en),
    .gauss_out_valid(gauss_out_valid), .scale_sel(scale_sel),
    .busy(busy), .pass_done(pass_done), .done(done), .err(err)
  );

  // Event monitors: writes, pass pulses (with the kernel index seen), frame pulses.
  always @(posedge clk) begin
    if (gauss_wr_en) wr_cnt++;
    if (pass_done) begin
      pd_cnt++;
      pd_hist = {pd_hist[4:0], scale_sel};
    end
    if (done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap;
    wb = wr_cnt; pb = pd_cnt; db = done_cnt;
  endtask

  task automatic go;
    start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int base = done_cnt;
    int k = 0;
    while (done_cnt == base && k < 60) begin tick; k++; end
    chk(tag, done_cnt - base, 1);
  endtask

  task automatic wait_pd(input string tag);
    int base = pd_cnt;
    int k = 0;
    while (pd_cnt == base && k < 60) begin tick; k++; end
    chk(tag, pd_cnt - base, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_pass_done", pass_done, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_scale_sel", scale_sel, 0);
    chk("rst_rd_en", src_rd_en, 0);
    chk("rst_wr_en", gauss_wr_en, 0);
    tick; tick; rst = 1'b1; tick;

    // nominal two-pass frame
    src_valid = 1'b1; gauss_out_valid = 1'b1; snap;
    go;
    chk("nom_busy", busy, 1);
    chk("nom_wr_comb", gauss_wr_en, 1);
    chk("nom_rd_comb", src_rd_en, 1);
    wait_done("nom_done");
    chk("nom_writes", wr_cnt - wb, 8);
    chk("nom_pass_done_cnt", pd_cnt - pb, 2);
    chk("nom_pass_sel", pd_hist[5:0], 6'b000_001);
    chk("nom_busy_end", busy, 0);
    chk("nom_sel_hold", scale_sel, 1);
    chk("nom_err", err, 0);
    tick; tick;
    chk("nom_one_done", done_cnt - db, 1);

    // backpressure for three cycles after the first write
    snap;
    go; tick;
    gauss_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_wr_off", gauss_wr_en, 0);
      chk("bp_rd_off", src_rd_en, 0);
      tick;
    end
    gauss_full = 1'b0;
    #1 chk("bp_wr_resume", gauss_wr_en, 1);
    wait_pd("bp_pass0");
    chk("bp_pass0_writes", wr_cnt - wb, 4);
    wait_done("bp_done");
    chk("bp_writes", wr_cnt - wb, 8);

    // drain timeout: three of four outputs arrive
    gauss_out_valid = 1'b0; snap;
    go; tick; tick; tick; tick;
    chk("to_drain_wr_off", gauss_wr_en, 0);
    chk("to_drain_busy", busy, 1);
    gauss_out_valid = 1'b1; tick; tick; tick; gauss_out_valid = 1'b0;
    n = 0;
    while (!err && n < 20) begin tick; n++; end
    chk("to_latency", n, 8);
    chk("to_busy", busy, 0);
    chk("to_no_pass_done", pd_cnt - pb, 0);
    chk("to_no_done", done_cnt - db, 0);
    tick; tick;
    chk("to_err_sticky", err, 1);

    // abort in pass 1 DRAIN
    gauss_out_valid = 1'b1; snap;
    go;
    chk("ab_err_clr", err, 0);
    n = 0;
    while (!pass_done && n < 20) begin tick; n++; end
    chk("ab_pass0", pass_done, 1);
    gauss_out_valid = 1'b0;
    tick;
    chk("ab_sel1", scale_sel, 1);
    tick; tick; tick; tick;
    abort = 1'b1; tick; abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_err_kept", err, 0);
    tick; tick;
    chk("ab_no_done", done_cnt - db, 0);
    gauss_out_valid = 1'b1; snap;
    go;
    chk("ab_restart_sel", scale_sel, 0);
    wait_done("ab_restart_done");
    chk("ab_restart_writes", wr_cnt - wb, 8);

    // abort during FEED blocks the write in that cycle
    snap;
    go; tick;
    abort = 1'b1;
    #1 chk("ab_feed_wr_off", gauss_wr_en, 0);
    tick; abort = 1'b0;
    chk("ab_feed_busy", busy, 0);
    chk("ab_feed_writes", wr_cnt - wb, 1);

    // asynchronous reset mid-FEED
    snap;
    go; tick; tick;
    chk("rs_two_writes", wr_cnt - wb, 2);
    rst = 1'b0;
    #1 chk("rs_outs", {busy, pass_done, done, err, src_rd_en, gauss_wr_en, scale_sel}, 0);
    tick; rst = 1'b1; tick;
    snap;
    go;
    wait_pd("rs_pass0");
    chk("rs_fresh_writes", wr_cnt - wb, 4);
    wait_done("rs_done");

    // start ignored in FEED; output valid on the 4th acceptance still counts
    gauss_out_valid = 1'b0; snap;
    go;
    gauss_out_valid = 1'b1;
    tick; start = 1'b1; tick; start = 1'b0; tick; tick;
    gauss_out_valid = 1'b0;
    n = 0;
    while (!pass_done && !err && n < 20) begin tick; n++; end
    chk("ec_pass_done", pass_done, 1);
    chk("ec_no_err", err, 0);
    chk("ec_writes", wr_cnt - wb, 4);
    gauss_out_valid = 1'b1;
    wait_done("ec_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gauss_pass_sequencer.md
GAUSS_PASS_SEQUENCER -- requirements
Module: gauss_pass_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter FRAME_PIXELS, default 4096, SHALL set the pixels per pass (legal range 2..65535).
REQ-003 Parameter NUM_SCALES, default 5, SHALL set the passes per frame (legal range 1..8).
REQ-004 Parameter DRAIN_TIMEOUT, default 1024, SHALL set the maximum idle cycles allowed in DRAIN.
REQ-005 Port clk, input, 1, SHALL be the sole clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, SHALL be the asynchronous active-low reset.
REQ-007 Port start, input, 1, SHALL request a frame run; sampled only in IDLE.
REQ-008 Port abort, input, 1, SHALL be a synchronous run cancel.
REQ-009 Port src_valid, input, 1, SHALL indicate a down-sampled pixel is available.
REQ-010 Port src_rd_en, output, 1, SHALL pop one source pixel.
REQ-011 Port gauss_full, input, 1, SHALL indicate the Gaussian input FIFO is full.
REQ-012 Port gauss_wr_en, output, 1, SHALL write one pixel into the Gaussian path.
REQ-013 Port gauss_out_valid, input, 1, SHALL mark one blurred pixel leaving the Gaussian path.
REQ-014 Port scale_sel, output, 3, SHALL give the kernel index of the current pass.
REQ-015 Port busy, output, 1, SHALL be high whenever state is not IDLE.
REQ-016 Port pass_done, output, 1, SHALL pulse once per completed pass.
REQ-017 Port done, output, 1, SHALL pulse once per completed frame.
REQ-018 Port err, output, 1, SHALL be a sticky drain-timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, FEED, DRAIN, NEXT and FIN.
REQ-020 IDLE with start=1 SHALL go to FEED next cycle: scale_sel=0, in_cnt=0, out_cnt=0, err cleared.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 In FEED, src_rd_en and gauss_wr_en SHALL be identical and combinational: src_valid AND NOT gauss_full, zero latency.
REQ-023 Both write enables SHALL be 0 in every state other than FEED.
REQ-024 Each accepted pixel SHALL increment in_cnt (16 bits).
REQ-025 Acceptance with in_cnt==FRAME_PIXELS-1 SHALL move FEED to DRAIN next cycle.
REQ-026 No pixel SHALL be accepted beyond FRAME_PIXELS in a pass.
REQ-027 gauss_out_valid in FEED or DRAIN SHALL increment out_cnt (16 bits), saturating at FRAME_PIXELS; this includes the FEED-to-DRAIN transition cycle.
REQ-028 gauss_out_valid in IDLE, NEXT or FIN SHALL be ignored.
REQ-029 DRAIN SHALL go to NEXT on the cycle after out_cnt reaches FRAME_PIXELS.
REQ-030 DRAIN SHALL keep an idle counter: reset on each gauss_out_valid, incremented otherwise.
REQ-031 When the idle counter reaches DRAIN_TIMEOUT, the block SHALL set err=1 and go to IDLE with no pass_done or done pulse.
REQ-032 NEXT SHALL last one cycle with pass_done=1.
REQ-033 From NEXT, if scale_sel==NUM_SCALES-1 the block SHALL go to FIN; otherwise it SHALL increment scale_sel, clear both counters and return to FEED.
REQ-034 FIN SHALL last one cycle with done=1, then go to IDLE; scale_sel SHALL hold its value.
REQ-035 abort=1 in any non-IDLE state SHALL go to IDLE next cycle and clear counters, with no pulses, err unchanged.
REQ-036 Write enables SHALL be 0 in the abort cycle.
REQ-037 abort SHALL take priority over every other transition, including timeout and pass completion.
REQ-038 pass_done, done, busy and err SHALL be registered outputs.

Reset
REQ-039 Asserting rst=0 SHALL immediately force state=IDLE, scale_sel=0, counters=0, and busy=pass_done=done=err=0.
REQ-040 Asserting rst=0 SHALL also force src_rd_en=gauss_wr_en=0, including when rst is asserted mid-pass.
REQ-041 Operation SHALL resume on the first clk edge after rst returns to 1.

Verification (FRAME_PIXELS=4, NUM_SCALES=2, DRAIN_TIMEOUT=8)
REQ-042 Nominal: start pulse, src_valid=1, gauss_full=0, output 4 valids per pass -> 8 writes total; pass_done pulses twice (scale_sel 0 then 1); one done pulse; busy returns to 0.
REQ-043 Backpressure: gauss_full=1 for 3 cycles mid-FEED -> src_rd_en=gauss_wr_en=0 during those 3 cycles; exactly 4 writes per pass.
REQ-044 Timeout: only 3 output valids in pass 0 -> err=1 8 cycles after the last valid; return to IDLE with no pass_done.
REQ-045 Abort: abort asserted in pass 1 DRAIN -> IDLE next cycle; no done; a following start runs cleanly from scale_sel=0.
REQ-046 Reset mid-FEED: rst=0 after 2 writes -> all outputs 0 immediately; a following start performs 4 fresh writes.
REQ-047 Edge cases: start during FEED -> ignored; gauss_out_valid coincident with the 4th acceptance -> counted toward out_cnt.
